rggen_native_initiator: RTL and testbench
=========================================

RGGEN_NATIVE_INITIATOR -- requirements
Module: rggen_native_initiator

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8: width of the request address and the bus address.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: width of write and read data.
REQ-003 SHALL have parameter STROBE_WIDTH, default BUS_WIDTH/8: width of the byte strobe.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64: number of BUS-state cycles before abort, minimum 1; used only when the timeout feature is compiled in (REQ-027).
REQ-005 SHALL have the following ports; one clock; reset is synchronous and active-high:
 i_clk  input  1  clock; all logic on the rising edge
 i_rst  input  1  reset, synchronous, active-high
 i_req_valid  input  1  request offered
 o_req_ready  output  1  request accepted when high together with i_req_valid
 i_req_access  input  2  rggen_access code (RGGEN_READ / RGGEN_WRITE)
 i_req_address  input  ADDRESS_WIDTH  byte address
 i_req_write_data  input  BUS_WIDTH  write data
 i_req_strobe  input  STROBE_WIDTH  byte enables
 o_rsp_valid  output  1  response available
 i_rsp_ready  input  1  response consumed when high together with o_rsp_valid
 o_rsp_status  output  2  rggen_status of the completed access
 o_rsp_read_data  output  BUS_WIDTH  read data
 o_busy  output  1  high in any state other than IDLE
 csrbus_if  rggen_bus_if.master  -  native bus; drives valid/access/address/write_data/strobe, samples ready/status/read_data

Function
REQ-006 SHALL implement a three-state FSM: IDLE, BUS, RESP; one transaction outstanding at most.
REQ-007 IDLE: o_req_ready SHALL be 1; in BUS and RESP it SHALL be 0, and i_req_* SHALL be ignored.
REQ-008 On an IDLE request handshake at edge N, SHALL register access/address/write_data/strobe and enter BUS; csrbus_if.valid SHALL be high from cycle N+1.
REQ-009 BUS: csrbus_if.valid SHALL stay 1 and all csrbus_if request fields SHALL stay stable until csrbus_if.ready is sampled high.
REQ-010 When csrbus_if.ready is sampled high at edge M, SHALL capture csrbus_if.status and csrbus_if.read_data, deassert csrbus_if.valid from cycle M+1, and enter RESP.
REQ-011 csrbus_if.valid SHALL never be high in IDLE or RESP; csrbus_if.ready seen outside BUS SHALL be ignored.
REQ-012 RESP: o_rsp_valid SHALL be 1 with o_rsp_status and o_rsp_read_data held stable until i_rsp_ready is sampled high, then the FSM SHALL return to IDLE.
REQ-013 For write accesses, o_rsp_read_data SHALL be all zeros regardless of csrbus_if.read_data.
REQ-014 Minimum turnaround SHALL be: response handshake at edge K, IDLE in cycle K+1, next request accepted no earlier than edge K+1.
REQ-015 Latency from bus ready to o_rsp_valid SHALL be exactly one cycle.
REQ-016 o_busy SHALL equal (state != IDLE).

Reset
REQ-017 i_rst high at a rising edge SHALL force state IDLE on the next cycle, regardless of current state.
REQ-018 Reset values: o_req_ready=1, o_rsp_valid=0, o_busy=0, csrbus_if.valid=0, o_rsp_status=2'b00, o_rsp_read_data=0, timeout counter=0.
REQ-019 Reset during BUS SHALL drop csrbus_if.valid on the next cycle; the transaction SHALL be lost with no response produced.
REQ-020 Reset during RESP SHALL discard the pending response.
REQ-021 Registered request fields MAY be left unreset; they SHALL not be observable while csrbus_if.valid is 0.

Configuration
REQ-022 Macro RGGEN_NATIVE_INITIATOR_TIMEOUT_EN SHALL control the timeout counter.
REQ-023 With the macro defined: the counter SHALL clear on entry to BUS and increment each BUS cycle without ready.
REQ-024 With the macro defined: when the count reaches TIMEOUT_CYCLES with ready low, SHALL deassert csrbus_if.valid the next cycle and enter RESP with status SLAVE_ERROR (2'b10) and read_data 0.
REQ-025 With the macro defined: ready sampled in the same cycle the count reaches TIMEOUT_CYCLES SHALL win and be treated as a normal completion.
REQ-026 Without the macro: no counter logic SHALL exist and BUS SHALL wait indefinitely for ready.
REQ-027 TIMEOUT_CYCLES SHALL have no effect when the macro is undefined.

Verification
REQ-028 Read, address 0x10, bus ready after 3 cycles with read_data 0xDEADBEEF and status 00 -> valid high for 3 cycles, o_rsp_valid one cycle after ready, read_data 0xDEADBEEF, status 00.
REQ-029 Write, address 0x04, data 0x12345678, strobe 4'b0011, bus ready immediately with read_data 0xFFFFFFFF -> fields stable while valid is high, response status 00 with read_data 0.
REQ-030 Response held with i_rsp_ready low for 5 cycles while i_req_valid stays high -> o_req_ready stays 0 and data is stable; second request accepted one cycle after the response handshake.
REQ-031 i_rst asserted in the second BUS cycle -> csrbus_if.valid is 0 the next cycle, no o_rsp_valid, o_req_ready=1.
REQ-032 With the macro defined, TIMEOUT_CYCLES=4 and ready held low -> valid drops after 4 BUS cycles, response status 2'b10 with data 0; a repeat run with ready arriving on the 4th cycle -> normal status 00.

Source files
------------

// File: rtl/rggen_native_initiator_if.sv
// Native register bus shared by the initiator and the register block.
// The initiator holds the request fields and valid; the block returns ready, status and read data.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int STROBE_WIDTH  = BUS_WIDTH / 8
);
  logic                     valid;
  logic [1:0]               access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [STROBE_WIDTH-1:0]  strobe;
  logic                     ready;
  logic [1:0]               status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_native_initiator.sv
// Single-outstanding bridge from a valid/ready request/response pair onto the native register bus.
// Optional bus timeout is compiled in with RGGEN_NATIVE_INITIATOR_TIMEOUT_EN.
module rggen_native_initiator #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int STROBE_WIDTH   = BUS_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 64
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [1:0]               i_req_access,
  input  logic [ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [BUS_WIDTH-1:0]     i_req_write_data,
  input  logic [STROBE_WIDTH-1:0]  i_req_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [1:0]               o_rsp_status,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic                     o_busy,
  rggen_bus_if.master              csrbus_if
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_e;

  // Bit 0 of the access code marks every write flavour (write and posted write).
  localparam int         WRITE_BIT   = 0;
  localparam logic [1:0] STATUS_OKAY = 2'b00;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                   state_r;
  logic                     req_ready_r;
  logic                     rsp_valid_r;
  logic                     busy_r;
  logic                     bus_valid_r;
  logic [1:0]               access_r;
  logic [ADDRESS_WIDTH-1:0] address_r;
  logic [BUS_WIDTH-1:0]     write_data_r;
  logic [STROBE_WIDTH-1:0]  strobe_r;
  logic [1:0]               rsp_status_r;
  logic [BUS_WIDTH-1:0]     rsp_read_data_r;

`ifdef RGGEN_NATIVE_INITIATOR_TIMEOUT_EN
  localparam int                     COUNT_WIDTH        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST       = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]             STATUS_SLAVE_ERROR = 2'b10;
  logic [COUNT_WIDTH-1:0]            timeout_count_r;
`endif

  // Transaction FSM; every externally visible signal is a register updated here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r         <= IDLE;
      req_ready_r     <= 1'b1;
      rsp_valid_r     <= 1'b0;
      busy_r          <= 1'b0;
      bus_valid_r     <= 1'b0;
      access_r        <= 2'b00;
      address_r       <= {ADDRESS_WIDTH{1'b0}};
      write_data_r    <= {BUS_WIDTH{1'b0}};
      strobe_r        <= {STROBE_WIDTH{1'b0}};
      rsp_status_r    <= STATUS_OKAY;
      rsp_read_data_r <= {BUS_WIDTH{1'b0}};
`ifdef RGGEN_NATIVE_INITIATOR_TIMEOUT_EN
      timeout_count_r <= {COUNT_WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (i_req_valid) begin
            access_r     <= i_req_access;
            address_r    <= i_req_address;
            write_data_r <= i_req_write_data;
            strobe_r     <= i_req_strobe;
            req_ready_r  <= 1'b0;
            busy_r       <= 1'b1;
            bus_valid_r  <= 1'b1;
            state_r      <= BUS;
`ifdef RGGEN_NATIVE_INITIATOR_TIMEOUT_EN
            timeout_count_r <= {COUNT_WIDTH{1'b0}};
`endif
          end
        end
        BUS: begin
          // A ready arriving on the final counted cycle still completes normally.
          if (csrbus_if.ready) begin
            rsp_status_r    <= csrbus_if.status;
            rsp_read_data_r <= access_r[WRITE_BIT] ? {BUS_WIDTH{1'b0}} : csrbus_if.read_data;
            bus_valid_r     <= 1'b0;
            rsp_valid_r     <= 1'b1;
            state_r         <= RESP;
          end
`ifdef RGGEN_NATIVE_INITIATOR_TIMEOUT_EN
          else if (timeout_count_r == TIMEOUT_LAST) begin
            timeout_count_r <= timeout_count_r + COUNT_WIDTH'(1);
            rsp_status_r    <= STATUS_SLAVE_ERROR;
            rsp_read_data_r <= {BUS_WIDTH{1'b0}};
            bus_valid_r     <= 1'b0;
            rsp_valid_r     <= 1'b1;
            state_r         <= RESP;
          end else begin
            timeout_count_r <= timeout_count_r + COUNT_WIDTH'(1);
          end
`endif
        end
        RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          bus_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready     = req_ready_r;
  assign o_rsp_valid     = rsp_valid_r;
  assign o_rsp_status    = rsp_status_r;
  assign o_rsp_read_data = rsp_read_data_r;
  assign o_busy          = busy_r;

  // Request fields are masked whenever valid is low so stale contents never leak onto the bus.
  assign csrbus_if.valid      = bus_valid_r;
  assign csrbus_if.access     = bus_valid_r ? access_r     : 2'b00;
  assign csrbus_if.address    = bus_valid_r ? address_r    : {ADDRESS_WIDTH{1'b0}};
  assign csrbus_if.write_data = bus_valid_r ? write_data_r : {BUS_WIDTH{1'b0}};
  assign csrbus_if.strobe     = bus_valid_r ? strobe_r     : {STROBE_WIDTH{1'b0}};

endmodule

// File: tb/tb_rggen_native_initiator.sv
// Scoreboard bench for rggen_native_initiator: a bus responder model plus a response monitor.
module tb_rggen_native_initiator;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_valid;
  logic          o_req_ready;
  logic [1:0]    i_req_access;
  logic [AW-1:0] i_req_address;
  logic [BW-1:0] i_req_write_data;
  logic [SW-1:0] i_req_strobe;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [1:0]    o_rsp_status;
  logic [BW-1:0] o_rsp_read_data;
  logic          o_busy;

  int total = 0;
  int bad   = 0;

  logic [33:0] sb[$];

  int          slv_delay;
  logic        slv_hold;
  logic [31:0] slv_rdata;
  logic [1:0]  slv_status;
  int          valid_cycles;

  logic [1:0]  exp_access;
  logic [7:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_strobe;

  always #5 clk = ~clk;

  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .STROBE_WIDTH(SW)) bus ();

  rggen_native_initiator #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .STROBE_WIDTH(SW), .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_access(i_req_access), .i_req_address(i_req_address),
    .i_req_write_data(i_req_write_data), .i_req_strobe(i_req_strobe),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_status(o_rsp_status), .o_rsp_read_data(o_rsp_read_data),
    .o_busy(o_busy), .csrbus_if(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [1:0] st, input logic [31:0] data);
    sb.push_back({st, data});
  endtask

  task automatic issue(input logic [1:0] acc, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
    int n = 0;
    exp_access = acc; exp_addr = addr; exp_wdata = wd; exp_strobe = st;
    i_req_access = acc; i_req_address = addr; i_req_write_data = wd; i_req_strobe = st;
    i_req_valid = 1'b1;
    while (!o_req_ready && n < 50) begin
      tick();
      n++;
    end
    check("req_accept_wait", n < 50, 1'b1);
    tick();
    i_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("rsp_drain", sb.size(), 0);
  endtask

  // Bus responder: checks request fields while valid, answers after slv_delay cycles,
  // and holds ready high with junk data while valid is low so stray ready is exercised.
  initial begin : responder
    int   cnt;
    logic rdy_prev;
    cnt = 0;
    rdy_prev = 1'b0;
    bus.ready = 1'b0; bus.status = 2'b00; bus.read_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rdy_prev) check("rsp_latency", o_rsp_valid, 1'b1);
      rdy_prev = 1'b0;
      if (bus.valid) begin
        valid_cycles++;
        check("bus_access", bus.access, exp_access);
        check("bus_addr", bus.address, exp_addr);
        check("bus_wdata", bus.write_data, exp_wdata);
        check("bus_strobe", bus.strobe, exp_strobe);
        check("bus_phase_flags", {o_busy, o_req_ready, o_rsp_valid}, 3'b100);
        if (!slv_hold && cnt >= slv_delay) begin
          bus.ready = 1'b1; bus.read_data = slv_rdata; bus.status = slv_status;
          rdy_prev = 1'b1;
          cnt = 0;
        end else begin
          bus.ready = 1'b0;
          cnt++;
        end
      end else begin
        bus.ready = 1'b1; bus.read_data = 32'hBAD0_0BAD; bus.status = 2'b11;
        cnt = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin : monitor
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (o_rsp_valid && i_rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("rsp_status", o_rsp_status, e[33:32]);
          check("rsp_data", o_rsp_read_data, e[31:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_access = 2'b00; i_req_address = 8'h0;
    i_req_write_data = 32'h0; i_req_strobe = 4'h0; i_rsp_ready = 1'b1;
    slv_delay = 0; slv_hold = 1'b0; slv_rdata = 32'h0; slv_status = 2'b00;
    valid_cycles = 0;
    exp_access = 2'b00; exp_addr = 8'h0; exp_wdata = 32'h0; exp_strobe = 4'h0;
    tick();
    tick();
    check("rst_req_ready", o_req_ready, 1'b1);
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_bus_valid", bus.valid, 1'b0);
    check("rst_rsp_status", o_rsp_status, 2'b00);
    check("rst_rsp_data", o_rsp_read_data, 32'h0);
    rst = 1'b0;
    tick();

    // Read with a three-cycle bus phase
    slv_delay = 2; slv_rdata = 32'hDEAD_BEEF; slv_status = 2'b00; valid_cycles = 0;
    expect_rsp(2'b00, 32'hDEAD_BEEF);
    issue(2'b10, 8'h10, 32'h0, 4'hF);
    drain();
    check("rd_valid_cycles", valid_cycles, 3);

    // Write with an immediate ready; read data must be zeroed
    slv_delay = 0; slv_rdata = 32'hFFFF_FFFF; slv_status = 2'b00; valid_cycles = 0;
    expect_rsp(2'b00, 32'h0);
    issue(2'b11, 8'h04, 32'h1234_5678, 4'b0011);
    drain();
    check("wr_valid_cycles", valid_cycles, 1);

    // Read returning EXOKAY, then a posted write returning DECODE_ERROR
    slv_delay = 1; slv_rdata = 32'h0BAD_F00D; slv_status = 2'b01;
    expect_rsp(2'b01, 32'h0BAD_F00D);
    issue(2'b10, 8'hFC, 32'h0, 4'hF);
    drain();
    slv_delay = 0; slv_rdata = 32'h5555_AAAA; slv_status = 2'b11;
    expect_rsp(2'b11, 32'h0);
    issue(2'b01, 8'h80, 32'hA5A5_0F0F, 4'b1000);
    drain();

    // Response back-pressure with a second request waiting
    i_rsp_ready = 1'b0;
    slv_delay = 1; slv_rdata = 32'hA5A5_5A5A; slv_status = 2'b01;
    expect_rsp(2'b01, 32'hA5A5_5A5A);
    issue(2'b10, 8'h20, 32'h0, 4'hF);
    i_req_access = 2'b11; i_req_address = 8'h24;
    i_req_write_data = 32'hCAFE_F00D; i_req_strobe = 4'b1100; i_req_valid = 1'b1;
    n = 0;
    while (!o_rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check("bp_rsp_wait", o_rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_req_ready", o_req_ready, 1'b0);
      check("bp_hold_data", o_rsp_read_data, 32'hA5A5_5A5A);
      check("bp_hold_status", o_rsp_status, 2'b01);
      tick();
    end
    exp_access = 2'b11; exp_addr = 8'h24; exp_wdata = 32'hCAFE_F00D; exp_strobe = 4'b1100;
    slv_rdata = 32'h1111_2222; slv_status = 2'b00;
    expect_rsp(2'b00, 32'h0);
    i_rsp_ready = 1'b1;
    tick();
    check("turn_idle", {o_req_ready, o_busy, o_rsp_valid}, 3'b100);
    tick();
    check("turn_accept", {o_req_ready, o_busy}, 2'b01);
    i_req_valid = 1'b0;
    drain();

    // Reset in the second bus cycle drops the transaction
    slv_hold = 1'b1; valid_cycles = 0;
    issue(2'b10, 8'h30, 32'h0, 4'hF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstbus_valid", bus.valid, 1'b0);
    check("rstbus_rsp_valid", o_rsp_valid, 1'b0);
    check("rstbus_req_ready", o_req_ready, 1'b1);
    check("rstbus_busy", o_busy, 1'b0);
    slv_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rstbus_no_rsp", o_rsp_valid, 1'b0);
      tick();
    end
    check("rstbus_valid_cycles", valid_cycles, 2);

`ifdef RGGEN_NATIVE_INITIATOR_TIMEOUT_EN
    // Bus never answers: abort after four cycles with SLAVE_ERROR
    slv_hold = 1'b1; valid_cycles = 0;
    expect_rsp(2'b10, 32'h0);
    issue(2'b10, 8'h40, 32'h0, 4'hF);
    drain();
    check("to_valid_cycles", valid_cycles, 4);
    // Ready on the fourth cycle wins over the timeout
    slv_hold = 1'b0; slv_delay = 3; slv_rdata = 32'h600D_F00D; slv_status = 2'b00;
    valid_cycles = 0;
    expect_rsp(2'b00, 32'h600D_F00D);
    issue(2'b10, 8'h44, 32'h0, 4'hF);
    drain();
    check("to_edge_valid_cycles", valid_cycles, 4);
`else
    // Without the timeout the bus phase waits as long as needed
    slv_delay = 20; slv_rdata = 32'h1357_9BDF; slv_status = 2'b00; valid_cycles = 0;
    expect_rsp(2'b00, 32'h1357_9BDF);
    issue(2'b10, 8'h44, 32'h0, 4'hF);
    drain();
    check("long_valid_cycles", valid_cycles, 21);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
